// File: rtl/emul_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : emul_bus_arbiter_if
// Description : Requester, peripheral-strobe and bus signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface emul_bus_arbiter_if;
  logic       tick;
  logic       in12_req;
  logic [7:0] in12_anode;
  logic [7:0] in12_cathode;
  logic       in12_done;
  logic       ms_req;
  logic [7:0] ms_addr;
  logic [7:0] ms_data;
  logic       ms_done;
  logic       ms_timeout;
  logic       ms6205_ready;
  logic       kb_req;
  logic [7:0] kb_col;
  logic       kb_done;
  logic [6:0] kb_row;
  logic [6:0] keyboard_data_in;
  logic [7:0] bus_data;
  logic       in12_write_anode;
  logic       in12_write_cathode;
  logic       in12_clear;
  logic       ms6205_write_addr_n;
  logic       ms6205_write_data_n;
  logic       keyboard_write;
  logic       keyboard_read;
  logic       keyboard_clear;
  logic [2:0] grant;
  logic       busy;

  modport master (
    output tick, in12_req, in12_anode, in12_cathode, ms_req, ms_addr, ms_data,
           ms6205_ready, kb_req, kb_col, keyboard_data_in,
    input  in12_done, ms_done, ms_timeout, kb_done, kb_row, bus_data,
           in12_write_anode, in12_write_cathode, in12_clear,
           ms6205_write_addr_n, ms6205_write_data_n,
           keyboard_write, keyboard_read, keyboard_clear, grant, busy
  );

  modport slave (
    input  tick, in12_req, in12_anode, in12_cathode, ms_req, ms_addr, ms_data,
           ms6205_ready, kb_req, kb_col, keyboard_data_in,
    output in12_done, ms_done, ms_timeout, kb_done, kb_row, bus_data,
           in12_write_anode, in12_write_cathode, in12_clear,
           ms6205_write_addr_n, ms6205_write_data_n,
           keyboard_write, keyboard_read, keyboard_clear, grant, busy
  );
endinterface
`default_nettype wire

// File: rtl/emul_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : emul_bus_arbiter
// Description : Round-robin owner of the shared emulator bus with tick-timed
//               setup/strobe/hold sequencing for IN12, MS6205 and keyboard.
// Revision    : 1.0 - initial release
// ============================================================================
module emul_bus_arbiter #(
  parameter int SETUP_TICKS   = 2,
  parameter int STROBE_TICKS  = 4,
  parameter int HOLD_TICKS    = 2,
  parameter int READY_TIMEOUT = 255
) (
  input wire logic          clk,
  input wire logic          rst,
  emul_bus_arbiter_if.slave arb
);

  localparam logic [7:0] SETUP_LAST   = 8'(SETUP_TICKS - 1);
  localparam logic [7:0] STROBE_LAST  = 8'(STROBE_TICKS - 1);
  localparam logic [7:0] HOLD_LAST    = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    SETUP    = 3'd2,
    STROBE   = 3'd3,
    HOLD     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t     state;
  logic [1:0] phase;
  logic [7:0] cnt;
  logic [2:0] last;
  logic [7:0] pay0;
  logic [7:0] pay1;
  logic       timed_out;
  logic [2:0] req_vec;
  logic [2:0] winner;
  logic       last_phase;

  // Search starts just after the previous owner; last=KB makes IN12 first.
  always_comb begin
    req_vec = {arb.kb_req, arb.ms_req, arb.in12_req};
    winner  = 3'b000;
    case (last)
      3'b001:  winner = req_vec[1] ? 3'b010 : req_vec[2] ? 3'b100 :
                        req_vec[0] ? 3'b001 : 3'b000;
      3'b010:  winner = req_vec[2] ? 3'b100 : req_vec[0] ? 3'b001 :
                        req_vec[1] ? 3'b010 : 3'b000;
      default: winner = req_vec[0] ? 3'b001 : req_vec[1] ? 3'b010 :
                        req_vec[2] ? 3'b100 : 3'b000;
    endcase
    last_phase = arb.grant[2] ? (phase == 2'd2) : (phase == 2'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      phase                   <= 2'd0;
      cnt                     <= 8'd0;
      last                    <= 3'b100;
      pay0                    <= 8'd0;
      pay1                    <= 8'd0;
      timed_out               <= 1'b0;
      arb.bus_data            <= 8'd0;
      arb.grant               <= 3'b000;
      arb.busy                <= 1'b0;
      arb.in12_done           <= 1'b0;
      arb.ms_done             <= 1'b0;
      arb.ms_timeout          <= 1'b0;
      arb.kb_done             <= 1'b0;
      arb.kb_row              <= 7'd0;
      arb.in12_write_anode    <= 1'b0;
      arb.in12_write_cathode  <= 1'b0;
      arb.in12_clear          <= 1'b0;
      arb.ms6205_write_addr_n <= 1'b1;
      arb.ms6205_write_data_n <= 1'b1;
      arb.keyboard_write      <= 1'b0;
      arb.keyboard_read       <= 1'b0;
      arb.keyboard_clear      <= 1'b0;
    end else begin
      arb.in12_done  <= 1'b0;
      arb.ms_done    <= 1'b0;
      arb.ms_timeout <= 1'b0;
      arb.kb_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (winner != 3'b000) begin
            arb.grant <= winner;
            arb.busy  <= 1'b1;
            phase     <= 2'd0;
            cnt       <= 8'd0;
            timed_out <= 1'b0;
            if (winner[0]) begin
              pay0         <= arb.in12_anode;
              pay1         <= arb.in12_cathode;
              arb.bus_data <= arb.in12_anode;
              state        <= SETUP;
            end else if (winner[1]) begin
              pay0         <= arb.ms_addr;
              pay1         <= arb.ms_data;
              arb.bus_data <= arb.ms_addr;
              state        <= WAIT_RDY;
            end else begin
              pay0         <= arb.kb_col;
              pay1         <= 8'd0;
              arb.bus_data <= arb.kb_col;
              state        <= SETUP;
            end
          end
        end
        WAIT_RDY: begin
          if (arb.ms6205_ready) begin
            cnt   <= 8'd0;
            state <= SETUP;
          end else if (arb.tick) begin
            if (cnt == TIMEOUT_LAST) begin
              cnt       <= 8'd0;
              timed_out <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        SETUP: begin
          if (arb.tick) begin
            if (cnt == SETUP_LAST) begin
              cnt   <= 8'd0;
              state <= STROBE;
              if (arb.grant[0]) begin
                if (phase == 2'd0) arb.in12_write_anode   <= 1'b1;
                else               arb.in12_write_cathode <= 1'b1;
              end else if (arb.grant[1]) begin
                if (phase == 2'd0) arb.ms6205_write_addr_n <= 1'b0;
                else               arb.ms6205_write_data_n <= 1'b0;
              end else begin
                if (phase == 2'd0)      arb.keyboard_write <= 1'b1;
                else if (phase == 2'd1) arb.keyboard_read  <= 1'b1;
                else                    arb.keyboard_clear <= 1'b1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        STROBE: begin
          if (arb.tick) begin
            if (cnt == STROBE_LAST) begin
              cnt                     <= 8'd0;
              state                   <= HOLD;
              arb.in12_write_anode    <= 1'b0;
              arb.in12_write_cathode  <= 1'b0;
              arb.ms6205_write_addr_n <= 1'b1;
              arb.ms6205_write_data_n <= 1'b1;
              arb.keyboard_write      <= 1'b0;
              arb.keyboard_read       <= 1'b0;
              arb.keyboard_clear      <= 1'b0;
              if (arb.grant[2] && phase == 2'd1) arb.kb_row <= arb.keyboard_data_in;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (arb.tick) begin
            if (cnt == HOLD_LAST) begin
              cnt <= 8'd0;
              if (last_phase) begin
                state <= DONE;
              end else begin
                phase        <= phase + 2'd1;
                arb.bus_data <= (phase == 2'd0) ? pay1 : 8'd0;
                state        <= arb.grant[1] ? WAIT_RDY : SETUP;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        DONE: begin
          arb.in12_done  <= arb.grant[0];
          arb.ms_done    <= arb.grant[1];
          arb.ms_timeout <= arb.grant[1] & timed_out;
          arb.kb_done    <= arb.grant[2];
          last           <= arb.grant;
          arb.grant      <= 3'b000;
          arb.busy       <= 1'b0;
          arb.bus_data   <= 8'd0;
          timed_out      <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_emul_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_emul_bus_arbiter
// Description : Scoreboard bench: directed requests queue expected bus events,
//               a monitor pops and compares them as the arbiter produces them.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_emul_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  emul_bus_arbiter_if bif();

  emul_bus_arbiter #(
    .SETUP_TICKS(2), .STROBE_TICKS(4), .HOLD_TICKS(2), .READY_TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(bif.slave)
  );

  typedef struct {
    int kind;
    int data;
    int aux;
    int len;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Event kinds: 0 grant, 10+i strobe i finished, 20 done pulse
  localparam int K_GRANT = 0;
  localparam int K_DONE  = 20;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expire(input string name, input int budget);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles, required one", name, budget);
  endtask

  task automatic push(input int kind, input int data, input int aux, input int len);
    ev_t e;
    e.kind = kind; e.data = data; e.aux = aux; e.len = len;
    exp_q.push_back(e);
  endtask

  // grant data: grant | busy<<3 | bus<<4 ; aux = clocks since previous done
  task automatic exp_grant(input int g, input int bus, input int gap);
    push(K_GRANT, g | 8 | (bus << 4), gap, -1);
  endtask

  // strobe index: 0 anode,1 cathode,2 addr_n,3 data_n,4 kb write,5 kb read,6 kb clear
  task automatic exp_strobe(input int idx, input int bus);
    push(10 + idx, bus, 4, 1);
  endtask

  // done data: {bus, grant, busy, timeout, kb, ms, in12}; aux = kb_row; len = ticks
  task automatic exp_done(input int src, input int to, input int row, input int len);
    push(K_DONE, src | (to << 3), row, len);
  endtask

  task automatic observe(input int kind, input int data, input int aux, input int len);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data 0x%0h, required no event", kind, data);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", kind, e.kind);
    if (kind == e.kind) begin
      if (kind == K_GRANT) begin
        check("grant_bus_busy", data, e.data);
        if (e.aux >= 0) check("grant_gap_clocks", aux, e.aux);
      end else if (kind == K_DONE) begin
        check("done_pulses", data, e.data);
        if (e.aux >= 0) check("done_kb_row", aux, e.aux);
        if (e.len >= 0) check("done_tick_length", len, e.len);
      end else begin
        check("strobe_bus", data, e.data);
        check("strobe_ticks", aux, e.aux);
        check("strobe_bus_stable", len, e.len);
      end
    end
  endtask

  // Tick: one clock high out of every four
  initial begin : tick_gen
    int tdiv;
    tdiv = 0;
    bif.tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % 4;
      bif.tick = (tdiv == 0);
    end
  end

  initial begin : monitor
    logic [6:0] s;
    logic [6:0] sp;
    logic [2:0] gprev;
    int width[7];
    int bus0[7];
    int stable[7];
    int glen;
    int since_done;
    sp = '0; gprev = '0; glen = 0; since_done = 1000;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        sp = '0; gprev = '0; since_done = 1000;
        continue;
      end
      s = {bif.keyboard_clear, bif.keyboard_read, bif.keyboard_write,
           ~bif.ms6205_write_data_n, ~bif.ms6205_write_addr_n,
           bif.in12_write_cathode, bif.in12_write_anode};
      if (gprev != 3'b000 && bif.tick) glen++;
      since_done++;
      for (int i = 0; i < 7; i++) begin
        if (sp[i] && bif.tick) width[i]++;
        if (s[i] && !sp[i]) begin
          width[i] = 0; bus0[i] = int'(bif.bus_data); stable[i] = 1;
        end else if (s[i] && int'(bif.bus_data) != bus0[i]) begin
          stable[i] = 0;
        end
        if (!s[i] && sp[i]) observe(10 + i, bus0[i], width[i], stable[i]);
      end
      if (bif.in12_done || bif.ms_done || bif.kb_done || bif.ms_timeout) begin
        observe(K_DONE,
                int'({bif.bus_data, bif.grant, bif.busy, bif.ms_timeout,
                      bif.kb_done, bif.ms_done, bif.in12_done}),
                int'(bif.kb_row), glen);
        since_done = 0;
      end
      if (gprev == 3'b000 && bif.grant != 3'b000) begin
        glen = 0;
        observe(K_GRANT, int'({bif.bus_data, bif.busy, bif.grant}), since_done, -1);
      end
      sp = s;
      gprev = bif.grant;
    end
  end

  task automatic wait_done(input int src, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if ((src == 0 && bif.in12_done) || (src == 1 && bif.ms_done) ||
          (src == 2 && bif.kb_done)) return;
    end
    expire("wait_done", budget);
  endtask

  task automatic wait_grant(input logic [2:0] g, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (bif.grant == g) return;
    end
    expire("wait_grant", budget);
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    seen = 0;
    while (seen < n) begin
      @(posedge clk);
      #2;
      if (bif.tick) seen++;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !bif.busy) break;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bif.in12_req = 1'b0; bif.in12_anode = 8'h00; bif.in12_cathode = 8'h00;
    bif.ms_req = 1'b0; bif.ms_addr = 8'h00; bif.ms_data = 8'h00;
    bif.ms6205_ready = 1'b1;
    bif.kb_req = 1'b0; bif.kb_col = 8'h00; bif.keyboard_data_in = 7'h00;

    // Reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_bus_data", int'(bif.bus_data), 0);
    check("rst_grant", int'(bif.grant), 0);
    check("rst_busy", int'(bif.busy), 0);
    check("rst_kb_row", int'(bif.kb_row), 0);
    check("rst_addr_n", int'(bif.ms6205_write_addr_n), 1);
    check("rst_data_n", int'(bif.ms6205_write_data_n), 1);
    check("rst_hi_strobes", int'({bif.in12_write_anode, bif.in12_write_cathode, bif.in12_clear,
                                  bif.keyboard_write, bif.keyboard_read, bif.keyboard_clear}), 0);
    check("rst_done", int'({bif.in12_done, bif.ms_done, bif.ms_timeout, bif.kb_done}), 0);
    do_reset();

    // 1: IN12 transfer; payload changes after grant are ignored
    exp_grant(1, 8'h35, -1);
    exp_strobe(0, 8'h35);
    exp_strobe(1, 8'h72);
    exp_done(1, 0, 0, 16);
    bif.in12_anode = 8'h35; bif.in12_cathode = 8'h72; bif.in12_req = 1'b1;
    wait_grant(3'b001, 20);
    bif.in12_anode = 8'hFF; bif.in12_cathode = 8'hEE;
    wait_done(0, 200);
    bif.in12_req = 1'b0;
    drain(50);

    // 2: MS6205 with ready low for 10 ticks
    exp_grant(2, 8'h10, -1);
    exp_strobe(2, 8'h10);
    exp_strobe(3, 8'hA5);
    exp_done(2, 0, 0, -1);
    bif.ms6205_ready = 1'b0;
    bif.ms_addr = 8'h10; bif.ms_data = 8'hA5; bif.ms_req = 1'b1;
    wait_grant(3'b010, 20);
    wait_ticks(10);
    bif.ms6205_ready = 1'b1;
    wait_done(1, 300);
    bif.ms_req = 1'b0;
    drain(50);

    // 3: MS6205 ready stuck low aborts after 255 ticks
    exp_grant(2, 8'h5A, -1);
    exp_done(2, 1, 0, 255);
    bif.ms6205_ready = 1'b0;
    bif.ms_addr = 8'h5A; bif.ms_data = 8'hC3; bif.ms_req = 1'b1;
    wait_done(1, 1200);
    bif.ms_req = 1'b0;
    bif.ms6205_ready = 1'b1;
    drain(50);

    // 4: keyboard write / read / clear with row capture
    exp_grant(4, 8'h04, -1);
    exp_strobe(4, 8'h04);
    exp_strobe(5, 8'h00);
    exp_strobe(6, 8'h00);
    exp_done(4, 0, 7'h2B, 24);
    bif.kb_col = 8'h04; bif.keyboard_data_in = 7'h2B; bif.kb_req = 1'b1;
    wait_done(2, 300);
    bif.kb_req = 1'b0;
    drain(50);

    // 5: all three requesters held from reset -> IN12, MS, KB, IN12
    do_reset();
    bif.in12_anode = 8'h11; bif.in12_cathode = 8'h22;
    bif.ms_addr = 8'h33; bif.ms_data = 8'h44;
    bif.kb_col = 8'h55; bif.keyboard_data_in = 7'h2B;
    exp_grant(1, 8'h11, -1);
    exp_strobe(0, 8'h11); exp_strobe(1, 8'h22);
    exp_done(1, 0, 0, 16);
    exp_grant(2, 8'h33, 1);
    exp_strobe(2, 8'h33); exp_strobe(3, 8'h44);
    exp_done(2, 0, 0, -1);
    exp_grant(4, 8'h55, 1);
    exp_strobe(4, 8'h55); exp_strobe(5, 8'h00); exp_strobe(6, 8'h00);
    exp_done(4, 0, 7'h2B, 24);
    exp_grant(1, 8'h11, 1);
    exp_strobe(0, 8'h11); exp_strobe(1, 8'h22);
    exp_done(1, 0, 7'h2B, 16);
    bif.in12_req = 1'b1; bif.ms_req = 1'b1; bif.kb_req = 1'b1;
    wait_done(2, 1000);
    bif.ms_req = 1'b0; bif.kb_req = 1'b0;
    wait_done(0, 300);
    bif.in12_req = 1'b0;
    drain(50);

    // 6: reset during the data strobe of an MS6205 transfer
    do_reset();
    bif.ms_addr = 8'h10; bif.ms_data = 8'h99;
    bif.in12_anode = 8'h35; bif.in12_cathode = 8'h72;
    exp_grant(2, 8'h10, -1);
    exp_strobe(2, 8'h10);
    bif.ms_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (!bif.ms6205_write_data_n) break;
    end
    check("data_strobe_reached", int'(bif.ms6205_write_data_n), 0);
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b1;
    #1;
    check("midrst_data_n", int'(bif.ms6205_write_data_n), 1);
    check("midrst_bus_data", int'(bif.bus_data), 0);
    check("midrst_grant", int'(bif.grant), 0);
    check("midrst_ms_done", int'(bif.ms_done), 0);
    bif.in12_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_grant(1, 8'h35, -1);
    exp_strobe(0, 8'h35); exp_strobe(1, 8'h72);
    exp_done(1, 0, 0, 16);
    exp_grant(2, 8'h10, 1);
    exp_strobe(2, 8'h10); exp_strobe(3, 8'h99);
    exp_done(2, 0, 0, -1);
    wait_done(0, 300);
    bif.in12_req = 1'b0;
    wait_done(1, 300);
    bif.ms_req = 1'b0;
    drain(50);

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/emul_bus_arbiter.md
Name: emul_bus_arbiter

Overview:
Shares the single 8-bit emulator output bus between three peripheral requesters: the IN12 tube driver, the MS6205 terminal and the keyboard scanner. It arbitrates requests round-robin, latches the winner's payload and drives it onto the bus. It generates the matching write, read and clear strobes with programmable setup, pulse and hold timing, counted in 1 us ticks. It replaces fixed-slot sequencing with request-driven scheduling, honours the MS6205 ready handshake, and captures keyboard row data.

Parameters:
SETUP_TICKS, 2, Tick count the bus is stable before a strobe is asserted (must be ≥1)
STROBE_TICKS, 4, Tick count the strobe is held active (must be ≥1)
HOLD_TICKS, 2, Tick count the bus is held after the strobe is released (must be ≥1)
READY_TIMEOUT, 255, maximum Tick count spent waiting for ms6205_ready (8-bit)

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous reset, active-high
Tick  in  1  one-Clk-wide 1 us enable; all phase counters advance only on Tick
in12_req  in  1  IN12 request; held until in12_done
in12_anode  in  8  anode payload
in12_cathode  in  8  cathode payload
in12_done  out  1  one-Clk pulse: IN12 transaction complete
ms_req  in  1  MS6205 request; held until ms_done
ms_addr  in  8  MS6205 address payload
ms_data  in  8  MS6205 data payload
ms_done  out  1  one-Clk pulse: MS6205 transaction ended
ms_timeout  out  1  one-Clk pulse coincident with ms_done when the transaction aborted
ms6205_ready  in  1  MS6205 ready, active-high
kb_req  in  1  keyboard request; held until kb_done
kb_col  in  8  keyboard column select payload
kb_done  out  1  one-Clk pulse: keyboard transaction complete
kb_row  out  7  captured keyboard row data
keyboard_data_in  in  7  raw keyboard row inputs
bus_data  out  8  shared emulator bus
in12_write_anode, in12_write_cathode, in12_clear  out  1 each  IN12 strobes, active-high
ms6205_write_addr_n, ms6205_write_data_n  out  1 each  MS6205 strobes, active-low
keyboard_write, keyboard_read, keyboard_clear  out  1 each  keyboard strobes, active-high
grant  out  3  one-hot owner: bit0 IN12, bit1 MS6205, bit2 keyboard
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, Rst=1):
  - bus_data=0; all active-high strobes 0; both _n strobes 1.
  - grant=0, busy=0, all done/timeout pulses 0, kb_row=0.
  - Round-robin pointer is set so IN12 has highest priority. FSM goes to IDLE.
  - Reset mid-transaction aborts immediately with no done pulse.
- All outputs are registered.
- FSM states: IDLE, WAIT_RDY, SETUP, STROBE, HOLD, DONE. A phase index (0..2) selects the current sub-transfer.
- IDLE:
  - On a Clk edge with any req high, grant the first requesting source after the last-granted source, in the order IN12→MS→KB→IN12.
  - On that edge: set grant, busy=1, latch all payload bytes, phase=0, counter=0.
  - Next state is WAIT_RDY if MS6205 is granted, otherwise SETUP.
- Transaction definitions (bus value / strobe per phase):
  - IN12: phase0 anode / in12_write_anode; phase1 cathode / in12_write_cathode.
  - MS6205: phase0 addr / ms6205_write_addr_n; phase1 data / ms6205_write_data_n. Each phase is preceded by WAIT_RDY.
  - KB: phase0 kb_col / keyboard_write; phase1 0x00 / keyboard_read; phase2 0x00 / keyboard_clear.
- SETUP, STROBE, HOLD:
  - Each state lasts exactly N Ticks and exits on the Clk edge where Tick=1 and counter==N-1. Counter resets to 0 on exit.
  - Strobe is asserted on entry to STROBE and deasserted on exit.
  - bus_data holds its value through all three states and is 0 only in IDLE.
- kb_row:
  - Captured from keyboard_data_in on the STROBE-exit edge of KB phase1.
  - Holds its value until the next capture or reset.
- HOLD exit:
  - If another phase remains: phase+1, then WAIT_RDY (MS) or SETUP.
  - Otherwise go to DONE.
- WAIT_RDY:
  - Leave for SETUP on the edge where ms6205_ready=1.
  - Otherwise count Ticks; on Tick with counter==READY_TIMEOUT-1, go to DONE with the timeout flag set.
- DONE (1 Clk):
  - Pulse the granted requester's done (plus ms_timeout if flagged).
  - Clear grant, busy=0, bus_data=0, pointer=granted source, return to IDLE.
  - A new grant is possible on the following edge.
- Boundary rules:
  - A req dropped mid-transaction is ignored; the transaction completes.
  - Requests arriving while busy wait; none are lost while held.
  - Payload changes after grant are ignored.
  - The same requester still asserting req after its done loses to any other pending requester.
  - Tick during DONE or IDLE has no effect.
- Minimum transaction length:
  - IN12: 2 × (S+P+H) Ticks.
  - KB: 3 × (S+P+H) Ticks.

Test Plan:
1. Reset, then in12_req with anode=0x35, cathode=0x72, default params → bus=0x35; in12_write_anode high for 4 Ticks after 2 Ticks of setup; then bus=0x72 with in12_write_cathode; in12_done one pulse after 16 Ticks; bus=0 after.
2. ms_req with addr=0x10, data=0xA5, ready held 0 for 10 Ticks, then 1 → no strobe during wait; ms6205_write_addr_n low 4 Ticks with bus=0x10; then data phase with bus=0xA5; ms_done pulsed, ms_timeout=0.
3. ms_req with ready stuck 0 → ms_done and ms_timeout pulse after exactly 255 Ticks; no _n strobe ever low; busy falls.
4. kb_req with col=0x04, keyboard_data_in=0x2B → write, read, clear strobes in sequence; kb_row=0x2B after the read strobe; bus=0x00 during read and clear; kb_done pulsed.
5. All three reqs asserted together from reset and held → grant order IN12, MS, KB, IN12; each done pulse is followed by a new grant on the next Clk.
6. Rst asserted during the STROBE of an MS6205 data phase → ms6205_write_data_n=1, bus=0, grant=0 immediately; no ms_done; after release with ms_req still high, IN12 is served first if also requesting.
